mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port memory controller between the IF stage (instruction fetch) and the MEM stage (loads/stores).
- Accepts level requests from both stages and grants one at a time, MEM having fixed priority over IF.
- Issues each granted access to the controller as a one-cycle command, waits for the controller's done, and returns data with a one-cycle ack.
- Supports IF flush: a fetch already in flight completes at the controller, but its result is discarded.

Parameters:
- ADDR_W, 32, address width (matches the memory address bus).
- WAIT_LIMIT, 255, cycles spent in WAIT before err_o is set; the wait counter is 8 bits.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous, active-low reset (0 = reset).
- rdy, input, 1, global ready; all state frozen while 0.
- if_req_i, input, 1, fetch request; held with if_addr_i until if_ack_o or flush.
- if_addr_i, input, ADDR_W, fetch address.
- if_flush_i, input, 1, kill the pending or in-flight fetch.
- if_ack_o, output, 1, one-cycle fetch completion.
- if_data_o, output, 32, fetched word, valid with if_ack_o.
- mem_req_i, input, 1, MEM request; held with its operands until mem_ack_o.
- mem_re_i, input, 2, 00 none / 01 byte / 10 half / 11 word.
- mem_we_i, input, 2, same encoding as mem_re_i.
- mem_rsign_i, input, 1, sign-extend loads.
- mem_addr_i, input, ADDR_W, data address.
- mem_wdata_i, input, 32, store data.
- mem_ack_o, output, 1, one-cycle MEM completion.
- mem_data_o, output, 32, load result, valid with mem_ack_o.
- mc_if_re_o, output, 1, controller fetch command.
- mc_if_addr_o, output, ADDR_W, controller fetch address.
- mc_mem_re_o, output, 2, controller load command.
- mc_mem_rsign_o, output, 1, controller load sign.
- mc_mem_addr_o, output, ADDR_W, controller data address.
- mc_mem_we_o, output, 2, controller store command.
- mc_mem_wdata_o, output, 32, controller store data.
- mc_busy_i, input, 1, controller busy.
- mc_done_i, input, 1, controller done.
- mc_data_i, input, 32, controller read data.
- err_o, output, 1, sticky watchdog error.

Behaviour:
- Reset: state=IDLE, every output 0, owner=none, killed=0, wait counter=0.
- rdy=0: state, registers and outputs are held.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If mem_req_i, latch the MEM operands, owner=MEM, go to ISSUE.
  - Else if if_req_i && !if_flush_i, latch if_addr_i, owner=IF, killed=0, go to ISSUE.
  - Else stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Drive the latched command on mc_* outputs; outside ISSUE every mc_* command output is 0.
  - For MEM: if we≠00, drive mc_mem_we_o and force mc_mem_re_o=00. If re=we=00, skip the controller and go directly to RESP with data 0.
  - For IF: mc_if_re_o=1.
  - Go to WAIT.
- WAIT:
  - Increment the wait counter (saturating).
  - On mc_done_i=1, capture mc_data_i into the owner's data register and go to RESP.
  - When the counter reaches WAIT_LIMIT, set err_o=1; it stays 1 until reset. Waiting continues; there is no abort.
- RESP (1 cycle):
  - mem_ack_o=1 if owner=MEM.
  - if_ack_o = (owner=IF && !killed && !if_flush_i).
  - Requests are not sampled in RESP; the requester drops its req on seeing ack.
  - Go to IDLE, clear the wait counter, owner=none.
- Flush:
  - if_flush_i in ISSUE or WAIT with owner=IF sets killed=1. The transaction still runs to mc_done_i, but no ack is given and if_data_o is unchanged.
  - Flush has no effect on MEM transactions.
  - An IF request present in IDLE in the same cycle as if_flush_i is not granted.
- Latency:
  - Controller cache hit (done one cycle after ISSUE): req sampled in cycle 0, ISSUE in cycle 1, done in cycle 2, ack in cycle 3.
  - Miss: ack comes one cycle after the controller's done.
- The controller is IDLE whenever the arbiter is in IDLE or ISSUE, because of the one-shot command and the RESP gap.
- Simultaneous mem_req_i and if_req_i in IDLE: MEM wins; IF stays pending.
- Reset mid-transaction: immediate return to the reset values. The controller is reset by the same rst.
- mc_busy_i is used for assertions only: it must be 0 during ISSUE.

Test Plan:
- Reset with rst=0 mid-WAIT -> all outputs 0 in the same cycle; after release, state IDLE and no ack appears.
- if_req_i=1, if_addr_i=0x100, controller done one cycle after ISSUE with data 0x00000013 -> mc_if_re_o high for exactly 1 cycle; if_ack_o=1 with if_data_o=0x00000013 in cycle 3.
- mem_req_i and if_req_i asserted in the same cycle; MEM word store 0xDEADBEEF to 0x200 -> mc_mem_we_o=11 first; mem_ack_o; then IF is issued after the RESP/IDLE gap, and if_ack_o follows.
- IF miss (done 4 cycles after ISSUE) with if_flush_i pulsed in WAIT -> no if_ack_o; if_data_o unchanged; next IF request proceeds normally.
- mem_req_i with re=we=00 -> no mc_* activity; mem_ack_o 2 cycles later with mem_data_o=0.
- mc_done_i held at 0 -> err_o=1 after 255 WAIT cycles and stays 1; a later done still produces the ack. Toggling rdy=0 mid-WAIT freezes the counter.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Arbiter sharing the single-port memory controller between IF and MEM.
// MEM has fixed priority; each grant becomes a one-cycle command, then waits for done.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_ack_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic [1:0]        mem_re_i,
  input  logic [1:0]        mem_we_i,
  input  logic              mem_rsign_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_ack_o,
  output logic [31:0]       mem_data_o,
  output logic              mc_if_re_o,
  output logic [ADDR_W-1:0] mc_if_addr_o,
  output logic [1:0]        mc_mem_re_o,
  output logic              mc_mem_rsign_o,
  output logic [ADDR_W-1:0] mc_mem_addr_o,
  output logic [1:0]        mc_mem_we_o,
  output logic [31:0]       mc_mem_wdata_o,
  input  logic              mc_busy_i,
  input  logic              mc_done_i,
  input  logic [31:0]       mc_data_i,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              killed_q, killed_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] if_addr_q, if_addr_d;
  logic [1:0]        mem_re_q, mem_re_d;
  logic [1:0]        mem_we_q, mem_we_d;
  logic              mem_rsign_q, mem_rsign_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_data_q, mem_data_d;

  logic if_flush_hit;
  assign if_flush_hit = if_flush_i && (owner_q == OWN_IF);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    killed_d    = killed_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    if_addr_d   = if_addr_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_rsign_d = mem_rsign_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          mem_re_d    = mem_re_i;
          mem_we_d    = mem_we_i;
          mem_rsign_d = mem_rsign_i;
          mem_addr_d  = mem_addr_i;
          mem_wdata_d = mem_wdata_i;
          owner_d     = OWN_MEM;
          state_d     = S_ISSUE;
        end else if (if_req_i && !if_flush_i) begin
          if_addr_d = if_addr_i;
          owner_d   = OWN_IF;
          killed_d  = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (if_flush_hit) killed_d = 1'b1;
        if (owner_q == OWN_MEM && mem_re_q == 2'b00 && mem_we_q == 2'b00) begin
          mem_data_d = '0;
          state_d    = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (32'(cnt_d) >= WAIT_LIMIT) err_d = 1'b1;
        if (if_flush_hit) killed_d = 1'b1;
        if (mc_done_i) begin
          state_d = S_RESP;
          // A flush arriving in the done cycle must also keep the stale word out.
          if (owner_q == OWN_MEM) mem_data_d = mc_data_i;
          else if (!(killed_q || if_flush_i)) if_data_d = mc_data_i;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      killed_q    <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      if_addr_q   <= '0;
      mem_re_q    <= '0;
      mem_we_q    <= '0;
      mem_rsign_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      killed_q    <= killed_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      if_addr_q   <= if_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_rsign_q <= mem_rsign_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
    end
  end

  logic issue_mem, mem_st, mem_ld;
  assign issue_mem = (state_q == S_ISSUE) && (owner_q == OWN_MEM);
  assign mem_st    = (mem_we_q != 2'b00);
  assign mem_ld    = !mem_st && (mem_re_q != 2'b00);

  assign mc_if_re_o     = (state_q == S_ISSUE) && (owner_q == OWN_IF);
  assign mc_if_addr_o   = mc_if_re_o ? if_addr_q : '0;
  assign mc_mem_we_o    = (issue_mem && mem_st) ? mem_we_q : '0;
  assign mc_mem_re_o    = (issue_mem && mem_ld) ? mem_re_q : '0;
  assign mc_mem_rsign_o = issue_mem && mem_ld && mem_rsign_q;
  assign mc_mem_addr_o  = (issue_mem && (mem_st || mem_ld)) ? mem_addr_q : '0;
  assign mc_mem_wdata_o = (issue_mem && mem_st) ? mem_wdata_q : '0;

  assign mem_ack_o  = (state_q == S_RESP) && (owner_q == OWN_MEM);
  assign if_ack_o   = (state_q == S_RESP) && (owner_q == OWN_IF) && !killed_q && !if_flush_i;
  assign if_data_o  = if_data_q;
  assign mem_data_o = mem_data_q;
  assign err_o      = err_q;

  // The one-shot command relies on the controller being idle when it is issued.
  a_idle_on_issue: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_ISSUE) |-> !mc_busy_i);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_arbiter: directed steps plus random transactions,
// with a behavioural memory controller and latency/data predictions from the protocol rules.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_flush_i = 1'b0;
  logic        if_ack_o;
  logic [31:0] if_data_o;
  logic        mem_req_i = 1'b0;
  logic [1:0]  mem_re_i = '0;
  logic [1:0]  mem_we_i = '0;
  logic        mem_rsign_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic        mem_ack_o;
  logic [31:0] mem_data_o;
  logic        mc_if_re_o;
  logic [31:0] mc_if_addr_o;
  logic [1:0]  mc_mem_re_o;
  logic        mc_mem_rsign_o;
  logic [31:0] mc_mem_addr_o;
  logic [1:0]  mc_mem_we_o;
  logic [31:0] mc_mem_wdata_o;
  logic        mc_busy_i = 1'b0;
  logic        mc_done_i = 1'b0;
  logic [31:0] mc_data_i = '0;
  logic        err_o;

  mem_arbiter #(.ADDR_W(32), .WAIT_LIMIT(255)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_ack_o(if_ack_o), .if_data_o(if_data_o),
    .mem_req_i(mem_req_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .mem_rsign_i(mem_rsign_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_ack_o(mem_ack_o), .mem_data_o(mem_data_o),
    .mc_if_re_o(mc_if_re_o), .mc_if_addr_o(mc_if_addr_o),
    .mc_mem_re_o(mc_mem_re_o), .mc_mem_rsign_o(mc_mem_rsign_o),
    .mc_mem_addr_o(mc_mem_addr_o), .mc_mem_we_o(mc_mem_we_o),
    .mc_mem_wdata_o(mc_mem_wdata_o),
    .mc_busy_i(mc_busy_i), .mc_done_i(mc_done_i), .mc_data_i(mc_data_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int lat_g = 1, flush_at_g = -1, rdy_lo_from = -1, rdy_lo_to = -1;
  int err0_cyc = -1, err1_cyc = -1;
  int n_if_iss, if_iss_cyc, n_mem_iss, mem_iss_cyc;
  int n_if_ack, if_ack_cyc, n_mem_ack, mem_ack_cyc;
  logic [31:0] if_ack_data, mem_ack_data;
  logic [31:0] exp_if_data = '0;
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Runs `budget` cycles from an IDLE cycle (cycle 0), acting as the controller and requesters.
  task automatic serve(input int budget);
    int done_at, iss_k;
    logic [31:0] reply;
    done_at = -1; iss_k = -1; reply = '0;
    n_if_iss = 0; if_iss_cyc = -1; n_mem_iss = 0; mem_iss_cyc = -1;
    n_if_ack = 0; if_ack_cyc = -1; n_mem_ack = 0; mem_ack_cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (k == err0_cyc) chk("err_still_low", 32'(err_o), 32'd0);
      if (k == err1_cyc) chk("err_set", 32'(err_o), 32'd1);
      if (mc_if_re_o) begin
        n_if_iss++; if_iss_cyc = k; iss_k = k; done_at = k + lat_g;
        chk("mc_if_addr", mc_if_addr_o, if_addr_i);
        reply = ref_read(if_addr_i);
      end
      if (mc_mem_re_o != 2'b00 || mc_mem_we_o != 2'b00) begin
        n_mem_iss++; mem_iss_cyc = k; iss_k = k; done_at = k + lat_g;
        chk("mc_mem_addr", mc_mem_addr_o, mem_addr_i);
        if (mem_we_i != 2'b00) begin
          chk("mc_mem_we", 32'(mc_mem_we_o), 32'(mem_we_i));
          chk("mc_mem_re_forced0", 32'(mc_mem_re_o), 32'd0);
          chk("mc_mem_wdata", mc_mem_wdata_o, mem_wdata_i);
          mem_model[mem_addr_i] = mem_wdata_i;
          reply = '0;
        end else begin
          chk("mc_mem_re", 32'(mc_mem_re_o), 32'(mem_re_i));
          chk("mc_mem_rsign", 32'(mc_mem_rsign_o), 32'(mem_rsign_i));
          reply = ref_read(mem_addr_i);
        end
      end
      if (if_ack_o) begin
        n_if_ack++; if_ack_cyc = k; if_ack_data = if_data_o; if_req_i = 1'b0;
      end
      if (mem_ack_o) begin
        n_mem_ack++; mem_ack_cyc = k; mem_ack_data = mem_data_o; mem_req_i = 1'b0;
      end
      mc_done_i  = (k == done_at);
      mc_data_i  = (k == done_at) ? reply : $urandom;
      mc_busy_i  = (k > iss_k) && (k < done_at);
      if_flush_i = (k == flush_at_g);
      if (k == flush_at_g) if_req_i = 1'b0;
      rdy = !(k >= rdy_lo_from && k < rdy_lo_to);
    end
    mc_done_i = 1'b0; mc_busy_i = 1'b0; if_flush_i = 1'b0; rdy = 1'b1;
  endtask

  task automatic do_if(input logic [31:0] a, input int lat, input int fl);
    logic [31:0] exp;
    exp = ref_read(a);
    lat_g = lat; flush_at_g = fl;
    if_req_i = 1'b1; if_addr_i = a;
    serve(lat + 8);
    if_req_i = 1'b0; flush_at_g = -1;
    chk("if_issue_pulses", 32'(n_if_iss), 32'd1);
    chk("if_issue_cyc", 32'(if_iss_cyc), 32'd1);
    chk("if_no_mem_ack", 32'(n_mem_ack), 32'd0);
    if (fl > 0) begin
      chk("if_killed_no_ack", 32'(n_if_ack), 32'd0);
      chk("if_killed_data_kept", if_data_o, exp_if_data);
    end else begin
      chk("if_ack_count", 32'(n_if_ack), 32'd1);
      chk("if_ack_cyc", 32'(if_ack_cyc), 32'(lat + 2));
      chk("if_data", if_ack_data, exp);
      exp_if_data = exp;
    end
  endtask

  task automatic do_mem(input logic [1:0] re, input logic [1:0] we, input logic rs,
                        input logic [31:0] a, input logic [31:0] wd, input int lat);
    logic [31:0] exp;
    logic none;
    none = (re == 2'b00) && (we == 2'b00);
    exp = (we != 2'b00 || none) ? 32'd0 : ref_read(a);
    lat_g = lat;
    mem_req_i = 1'b1; mem_re_i = re; mem_we_i = we; mem_rsign_i = rs;
    mem_addr_i = a; mem_wdata_i = wd;
    serve(lat + 8);
    mem_req_i = 1'b0;
    chk("mem_issue_pulses", 32'(n_mem_iss), none ? 32'd0 : 32'd1);
    chk("mem_no_if_issue", 32'(n_if_iss), 32'd0);
    chk("mem_ack_count", 32'(n_mem_ack), 32'd1);
    chk("mem_ack_cyc", 32'(mem_ack_cyc), none ? 32'd2 : 32'(lat + 2));
    chk("mem_data", mem_ack_data, exp);
  endtask

  initial begin
    mem_model[32'h100] = 32'h0000_0013;

    // Reset values
    #1;
    chk("reset_ctrl_bits", {25'd0, if_ack_o, mem_ack_o, mc_if_re_o, mc_mem_re_o != 2'b00,
        mc_mem_we_o != 2'b00, mc_mem_rsign_o, err_o}, 32'd0);
    chk("reset_if_data", if_data_o, 32'd0);
    chk("reset_mem_data", mem_data_o, 32'd0);
    chk("reset_mc_buses", mc_if_addr_o | mc_mem_addr_o | mc_mem_wdata_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Cache-hit fetch: ack in cycle 3
    do_if(32'h100, 1, -1);
    chk("hit_fetch_word", if_ack_data, 32'h0000_0013);

    // MEM and IF together: MEM store first, IF after the RESP/IDLE gap
    lat_g = 2;
    mem_req_i = 1'b1; mem_re_i = 2'b00; mem_we_i = 2'b11; mem_rsign_i = 1'b0;
    mem_addr_i = 32'h200; mem_wdata_i = 32'hDEAD_BEEF;
    if_req_i = 1'b1; if_addr_i = 32'h104;
    serve(16);
    mem_req_i = 1'b0; if_req_i = 1'b0;
    chk("prio_mem_issue_cyc", 32'(mem_iss_cyc), 32'd1);
    chk("prio_mem_ack_cyc", 32'(mem_ack_cyc), 32'd4);
    chk("prio_if_issue_cyc", 32'(if_iss_cyc), 32'd6);
    chk("prio_if_ack_cyc", 32'(if_ack_cyc), 32'd9);
    chk("prio_if_data", if_ack_data, ref_read(32'h104));
    exp_if_data = ref_read(32'h104);
    do_mem(2'b11, 2'b00, 1'b0, 32'h200, 32'h0, 3);
    chk("load_back_store", mem_ack_data, 32'hDEAD_BEEF);

    // Zero-op MEM: no controller command, ack 2 cycles later with 0
    do_mem(2'b00, 2'b00, 1'b1, 32'h300, 32'h1234_5678, 1);

    // Flushed miss, then a normal fetch
    do_if(32'h180, 4, 3);
    do_if(32'h184, 2, -1);

    // Random mix
    for (int i = 0; i < 30; i++) begin
      int kind, lat;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      lat  = int'($urandom_range(1, 6));
      a    = 32'h400 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      case (kind)
        0: do_if(a, lat, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat + 1)) : -1);
        1: do_mem(2'($urandom_range(1, 3)), 2'b00, 1'($urandom), a, $urandom, lat);
        2: do_mem(2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)), 1'($urandom), a, $urandom, lat);
        default: do_mem(2'b00, 2'b00, 1'($urandom), a, $urandom, lat);
      endcase
    end

    // Watchdog with a 10-cycle rdy freeze mid-WAIT; late done still acks
    err0_cyc = 266; err1_cyc = 267; rdy_lo_from = 100; rdy_lo_to = 110;
    do_if(32'h500, 299, -1);
    err0_cyc = -1; err1_cyc = -1; rdy_lo_from = -1; rdy_lo_to = -1;
    chk("err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of WAIT
    lat_g = 50; if_req_i = 1'b1; if_addr_i = 32'h600;
    serve(5);
    #2 rst = 1'b0; if_req_i = 1'b0;
    #1;
    chk("midreset_ctrl_bits", {25'd0, if_ack_o, mem_ack_o, mc_if_re_o, mc_mem_re_o != 2'b00,
        mc_mem_we_o != 2'b00, mc_mem_rsign_o, err_o}, 32'd0);
    chk("midreset_if_data", if_data_o, 32'd0);
    exp_if_data = '0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    serve(10);
    chk("post_reset_no_ack", 32'(n_if_ack + n_mem_ack), 32'd0);
    chk("post_reset_no_issue", 32'(n_if_iss + n_mem_iss), 32'd0);
    do_if(32'h100, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
